// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared glyph codes, mode/state encodings for the segment display
// Purpose: constants and enums shared by seg_anim_display and its glyph decoder.
// Ports: none (package).
package seg_pkg;

  localparam logic [4:0] GLY_BLANK = 5'd16;
  localparam logic [4:0] GLY_DASH  = 5'd17;
  localparam logic [4:0] GLY_P     = 5'd18;
  localparam logic [4:0] GLY_L     = 5'd19;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_REVEAL = 2'd1,
    MODE_SCROLL = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // What the display buffer does on a given cycle.
  typedef enum logic [2:0] {
    DOP_NONE  = 3'd0,
    DOP_LOAD  = 3'd1,
    DOP_BLANK = 3'd2,
    DOP_SHIFT = 3'd3,
    DOP_ROT   = 3'd4
  } disp_op_e;

endpackage

// File: rtl/seg_anim_display_if.sv
// rtl/seg_anim_display_if.sv - frame load / status interface of the segment display
// Purpose: groups the controller-facing signals of seg_anim_display.
// Signals: load (strobe), mode[1:0], glyphs[5*NUM_DIGITS-1:0], dp_mask, busy, done.
// Modports: master = controller (drives load/mode/glyphs/dp_mask), slave = display.
interface seg_anim_display_if #(
  parameter int NUM_DIGITS = 8
);
  logic                    load;
  logic [1:0]              mode;
  logic [5*NUM_DIGITS-1:0] glyphs;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic                    busy;
  logic                    done;

  modport master (output load, mode, glyphs, dp_mask, input busy, done);
  modport slave  (input load, mode, glyphs, dp_mask, output busy, done);
endinterface

// File: rtl/glyph_seg_decoder.sv
// rtl/glyph_seg_decoder.sv - glyph code to active-high 7-segment pattern
// Purpose: combinational decode of a 5-bit glyph code plus decimal point.
// Ports: code[4:0] in, dp in, seg[7:0] out = {dp,g,f,e,d,c,b,a}, active-high.
module glyph_seg_decoder
  import seg_pkg::*;
(
  input  logic [4:0] code,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [6:0] gfedcba;

  always_comb begin
    gfedcba = 7'h00;
    case (code)
      5'd0:     gfedcba = 7'h3F;
      5'd1:     gfedcba = 7'h06;
      5'd2:     gfedcba = 7'h5B;
      5'd3:     gfedcba = 7'h4F;
      5'd4:     gfedcba = 7'h66;
      5'd5:     gfedcba = 7'h6D;
      5'd6:     gfedcba = 7'h7D;
      5'd7:     gfedcba = 7'h07;
      5'd8:     gfedcba = 7'h7F;
      5'd9:     gfedcba = 7'h6F;
      5'd10:    gfedcba = 7'h77;
      5'd11:    gfedcba = 7'h7C;
      5'd12:    gfedcba = 7'h39;
      5'd13:    gfedcba = 7'h5E;
      5'd14:    gfedcba = 7'h79;
      5'd15:    gfedcba = 7'h71;
      GLY_DASH: gfedcba = 7'h40;
      GLY_P:    gfedcba = 7'h73;
      GLY_L:    gfedcba = 7'h38;
      default:  gfedcba = 7'h00;
    endcase
    seg = {dp, gfedcba};
  end

endmodule

// File: rtl/seg_anim_display.sv
// rtl/seg_anim_display.sv - N-digit multiplexed 7-segment driver with frame animation
// Purpose: latches a glyph frame and scans it onto a shared segment bus, with
//   static, right-to-left reveal, marquee scroll and blink modes.
// Ports: clk, rst (async, active-high); ctl (seg_anim_display_if.slave: load,
//   mode, glyphs, dp_mask in; busy, done out); seg_out[7:0] {dp,g..a};
//   seg_en[NUM_DIGITS-1:0] one-hot digit enable. Pin polarity set by ACTIVE_LOW.
module seg_anim_display
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100_000,
  parameter int STEP_DIV   = 50_000_000,
  parameter bit ACTIVE_LOW = 1'b1
)(
  input  logic                  clk,
  input  logic                  rst,
  seg_anim_display_if.slave     ctl,
  output logic [7:0]            seg_out,
  output logic [NUM_DIGITS-1:0] seg_en
);

  localparam int IW  = $clog2(NUM_DIGITS);
  localparam int KW  = $clog2(NUM_DIGITS + 1);
  localparam int SCW = $clog2(SCAN_DIV);
  localparam int STW = $clog2(STEP_DIV);

  localparam logic [7:0]            SEG_OFF = {8{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] EN_OFF  = {NUM_DIGITS{ACTIVE_LOW}};

  logic [SCW-1:0] scan_cnt;
  logic [STW-1:0] step_cnt;
  logic           scan_tick;
  logic           step_tick;
  logic [IW-1:0]  scan_idx;

  state_e   state_q, state_d;
  mode_e    mode_q;
  disp_op_e disp_op;
  logic     ld_frame, k_clr, k_inc, blank_clr, blank_tog;
  logic     busy_d, done_d, busy_q, done_q, blank_q;

  logic [4:0]            frame_q [NUM_DIGITS];
  logic [4:0]            disp_q  [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] dpm_q;
  logic [KW-1:0]         k_q;
  logic [IW-1:0]         rev_idx;

  logic [4:0]            cur_code;
  logic                  cur_dp;
  logic [7:0]            dec_seg;
  logic [7:0]            pat;
  logic [NUM_DIGITS-1:0] en_raw;

  assign ctl.busy = busy_q;
  assign ctl.done = done_q;

  // Free-running prescalers; load never touches them.
  assign scan_tick = (scan_cnt == SCW'(SCAN_DIV - 1));
  assign step_tick = (step_cnt == STW'(STEP_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      step_cnt <= '0;
      scan_idx <= '0;
    end else begin
      scan_cnt <= scan_tick ? '0 : scan_cnt + 1'b1;
      step_cnt <= step_tick ? '0 : step_cnt + 1'b1;
      if (scan_tick)
        scan_idx <= (scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
    end
  end

  // Reveal inserts the frame from its leftmost digit downwards.
  assign rev_idx = IW'(KW'(NUM_DIGITS - 1) - k_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // A load always wins over anything else happening in the same cycle.
  always_comb begin
    state_d   = state_q;
    disp_op   = DOP_NONE;
    ld_frame  = 1'b0;
    k_clr     = 1'b0;
    k_inc     = 1'b0;
    blank_clr = 1'b0;
    blank_tog = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    if (ctl.load) begin
      ld_frame  = 1'b1;
      k_clr     = 1'b1;
      blank_clr = 1'b1;
      case (mode_e'(ctl.mode))
        MODE_STATIC: begin
          disp_op = DOP_LOAD;
          state_d = ST_HOLD;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
        MODE_REVEAL: begin
          disp_op = DOP_BLANK;
          state_d = ST_RUN;
          busy_d  = 1'b1;
        end
        default: begin
          disp_op = DOP_LOAD;
          state_d = ST_RUN;
          busy_d  = 1'b1;
        end
      endcase
    end else if (state_q == ST_RUN) begin
      case (mode_q)
        MODE_REVEAL: begin
          // k == NUM_DIGITS marks the cycle after the final shift.
          if (k_q == KW'(NUM_DIGITS)) begin
            state_d = ST_HOLD;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (step_tick) begin
            disp_op = DOP_SHIFT;
            k_inc   = 1'b1;
          end
        end
        MODE_SCROLL: if (step_tick) disp_op = DOP_ROT;
        MODE_BLINK:  if (step_tick) blank_tog = 1'b1;
        default: begin
          state_d = ST_HOLD;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        frame_q[i] <= GLY_BLANK;
        disp_q[i]  <= GLY_BLANK;
      end
      dpm_q   <= '0;
      mode_q  <= MODE_STATIC;
      k_q     <= '0;
      blank_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      if (ld_frame) begin
        for (int i = 0; i < NUM_DIGITS; i++)
          frame_q[i] <= ctl.glyphs[5*i +: 5];
        dpm_q  <= ctl.dp_mask;
        mode_q <= mode_e'(ctl.mode);
      end
      if (k_clr)      k_q <= '0;
      else if (k_inc) k_q <= k_q + 1'b1;
      if (blank_clr)      blank_q <= 1'b0;
      else if (blank_tog) blank_q <= ~blank_q;
      case (disp_op)
        DOP_LOAD:
          for (int i = 0; i < NUM_DIGITS; i++) disp_q[i] <= ctl.glyphs[5*i +: 5];
        DOP_BLANK:
          for (int i = 0; i < NUM_DIGITS; i++) disp_q[i] <= GLY_BLANK;
        DOP_SHIFT: begin
          disp_q[0] <= frame_q[rev_idx];
          for (int i = 1; i < NUM_DIGITS; i++) disp_q[i] <= disp_q[i-1];
        end
        DOP_ROT: begin
          disp_q[0] <= disp_q[NUM_DIGITS-1];
          for (int i = 1; i < NUM_DIGITS; i++) disp_q[i] <= disp_q[i-1];
        end
        default: ;
      endcase
    end
  end

  assign cur_code = disp_q[scan_idx];
  assign cur_dp   = dpm_q[scan_idx];

  glyph_seg_decoder u_dec (
    .code (cur_code),
    .dp   (cur_dp),
    .seg  (dec_seg)
  );

  always_comb begin
    en_raw           = '0;
    en_raw[scan_idx] = 1'b1;
    pat              = blank_q ? 8'h00 : dec_seg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_out <= SEG_OFF;
      seg_en  <= EN_OFF;
    end else begin
      seg_out <= pat ^ SEG_OFF;
      seg_en  <= en_raw ^ EN_OFF;
    end
  end

endmodule

// File: tb/tb_seg_anim_display.sv
// tb/tb_seg_anim_display.sv - self-checking bench for seg_anim_display
module tb_seg_anim_display;
  localparam int N   = 4;
  localparam int SD  = 2;
  localparam int STD = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [7:0]   seg_out;
  logic [N-1:0] seg_en;

  seg_anim_display_if #(.NUM_DIGITS(N)) bus ();

  seg_anim_display #(
    .NUM_DIGITS (N),
    .SCAN_DIV   (SD),
    .STEP_DIV   (STD),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ctl     (bus.slave),
    .seg_out (seg_out),
    .seg_en  (seg_en)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: frame, mode and number of steps taken since the last load.
  int           ne;
  int           m_frame [N];
  logic [N-1:0] m_dpm;
  int           m_mode;
  int           m_s;
  bit           m_loaded, m_run, m_pend;
  logic         m_busy, m_done;
  logic [N-1:0] exp_en;
  logic [7:0]   exp_seg;

  function automatic logic [6:0] ref_seg(input int code);
    case (code)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F; 10: return 7'h77; 11: return 7'h7C;
      12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; 15: return 7'h71;
      17: return 7'h40; 18: return 7'h73; 19: return 7'h38;
      default: return 7'h00;
    endcase
  endfunction

  function automatic int disp_of(input int j);
    if (!m_loaded) return 16;
    case (m_mode)
      1: return (j < m_s) ? m_frame[N - m_s + j] : 16;
      2: return m_frame[((j - m_s) % N + N) % N];
      default: return m_frame[j];
    endcase
  endfunction

  task automatic model_clear();
    ne = 0; m_loaded = 0; m_run = 0; m_pend = 0; m_s = 0; m_mode = 0;
    m_dpm = '0; m_busy = 1'b0; m_done = 1'b0;
    for (int i = 0; i < N; i++) m_frame[i] = 16;
  endtask

  task automatic model_edge();
    int   prev, ip;
    bit   tick, blank;
    logic [7:0] pat;
    logic [N-1:0] oh;
    prev  = ne;
    tick  = (prev % STD) == STD - 1;
    ip    = (prev / SD) % N;
    blank = (m_mode == 3) && (m_s % 2 == 1) && m_loaded;
    oh    = '0;
    oh[ip] = 1'b1;
    exp_en = ~oh;
    pat    = blank ? 8'h00 : {m_dpm[ip], ref_seg(disp_of(ip))};
    exp_seg = ~pat;
    m_done = 1'b0;
    if (bus.load) begin
      m_loaded = 1; m_s = 0; m_pend = 0;
      m_mode = int'(bus.mode);
      m_dpm  = bus.dp_mask;
      for (int i = 0; i < N; i++) m_frame[i] = int'(bus.glyphs[5*i +: 5]);
      if (m_mode == 0) begin m_done = 1'b1; m_busy = 1'b0; m_run = 0; end
      else begin m_busy = 1'b1; m_run = 1; end
    end else if (m_pend) begin
      m_pend = 0; m_run = 0; m_done = 1'b1; m_busy = 1'b0;
    end else if (m_run && tick) begin
      m_s++;
      if (m_mode == 1 && m_s == N) m_pend = 1;
    end
    ne++;
  endtask

  task automatic tick_cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("seg_en", 32'(seg_en), 32'(exp_en));
    check("seg_out", 32'(seg_out), 32'(exp_seg));
    check("busy", 32'(bus.busy), 32'(m_busy));
    check("done", 32'(bus.done), 32'(m_done));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick_cycle();
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    bus.load = 1'b0;
    #2;
    check({tag, "_en"}, 32'(seg_en), 32'hF);
    check({tag, "_seg"}, 32'(seg_out), 32'hFF);
    check({tag, "_busy"}, 32'(bus.busy), 32'h0);
    check({tag, "_done"}, 32'(bus.done), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic load_frame(input int md, input logic [5*N-1:0] g, input logic [N-1:0] dm);
    bus.load    = 1'b1;
    bus.mode    = 2'(md);
    bus.glyphs  = g;
    bus.dp_mask = dm;
    tick_cycle();
    bus.load = 1'b0;
  endtask

  initial begin
    int guard;
    bus.load = 1'b0; bus.mode = 2'd0; bus.glyphs = '0; bus.dp_mask = '0;
    model_clear();
    #2;
    do_reset("por");
    run(6);

    load_frame(0, {5'd3, 5'd2, 5'd1, 5'd0}, 4'b0000);
    run(20);

    load_frame(1, {5'd18, 5'd1, 5'd16, 5'd5}, 4'b0000);
    run(4 * STD + 6);

    load_frame(1, {5'd18, 5'd1, 5'd16, 5'd5}, 4'b0010);
    run(12);
    do_reset("mid");
    run(4);

    load_frame(2, {5'd10, 5'd11, 5'd12, 5'd13}, 4'b0000);
    run(5 * STD);

    load_frame(3, {5'd8, 5'd8, 5'd8, 5'd8}, 4'b0001);
    run(4 * STD);

    load_frame(1, {5'd2, 5'd4, 5'd6, 5'd8}, 4'b0000);
    guard = 0;
    while (!(m_s == N - 1 && (ne % STD) == STD - 1) && guard < 200) begin
      tick_cycle();
      guard++;
    end
    check("collide_sync", 32'(guard < 200), 32'h1);
    load_frame(1, {5'd19, 5'd17, 5'd9, 5'd7}, 4'b1000);
    check("collide_k", 32'(m_s), 32'h0);
    run(5 * STD);

    for (int c = 0; c < 800; c++) begin
      bus.mode = 2'($urandom_range(0, 3));
      bus.glyphs = '0;
      for (int i = 0; i < N; i++) bus.glyphs[5*i +: 5] = 5'($urandom_range(0, 31));
      bus.dp_mask = 4'($urandom_range(0, 15));
      bus.load = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 399) == 0) do_reset("rnd");
      else tick_cycle();
    end
    bus.load = 1'b0;
    run(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
